// File: rtl/column_sum_17_if.sv
// ---------------------------------------------------------------------------
// column_sum_17_if
//   Bundle between the 16-row line buffer side and the column summer.
//   The master drives one vertical column of 17 taps per valid beat plus the
//   end-of-frame pulse. The slave returns the 17-tap sum, its column index,
//   a one-cycle valid qualifier and the drained end-of-frame pulse.
//
// Signals
//   valid_i              master->slave  taps carry a new column this cycle
//   data0_i..data16_i    master->slave  8-bit taps, data0_i newest row,
//                                       data16_i oldest row
//   done_i               master->slave  one-cycle end-of-frame pulse
//   sum_o       [12:0]   slave->master  sum of the 17 taps
//   col_o       [CW-1:0] slave->master  column index belonging to sum_o
//   sum_valid_o          slave->master  sum_o/col_o qualifier
//   done_o               slave->master  end-of-frame pulse after drain
// ---------------------------------------------------------------------------
interface column_sum_17_if #(
    parameter int CW = 10
);
    logic          valid_i;
    logic [7:0]    data0_i;
    logic [7:0]    data1_i;
    logic [7:0]    data2_i;
    logic [7:0]    data3_i;
    logic [7:0]    data4_i;
    logic [7:0]    data5_i;
    logic [7:0]    data6_i;
    logic [7:0]    data7_i;
    logic [7:0]    data8_i;
    logic [7:0]    data9_i;
    logic [7:0]    data10_i;
    logic [7:0]    data11_i;
    logic [7:0]    data12_i;
    logic [7:0]    data13_i;
    logic [7:0]    data14_i;
    logic [7:0]    data15_i;
    logic [7:0]    data16_i;
    logic          done_i;
    logic [12:0]   sum_o;
    logic [CW-1:0] col_o;
    logic          sum_valid_o;
    logic          done_o;

    // Upstream side: line buffer / stimulus.
    modport master (
        output valid_i,
        output data0_i, data1_i, data2_i, data3_i, data4_i, data5_i,
        output data6_i, data7_i, data8_i, data9_i, data10_i, data11_i,
        output data12_i, data13_i, data14_i, data15_i, data16_i,
        output done_i,
        input  sum_o, col_o, sum_valid_o, done_o
    );

    // Column summer side.
    modport slave (
        input  valid_i,
        input  data0_i, data1_i, data2_i, data3_i, data4_i, data5_i,
        input  data6_i, data7_i, data8_i, data9_i, data10_i, data11_i,
        input  data12_i, data13_i, data14_i, data15_i, data16_i,
        input  done_i,
        output sum_o, col_o, sum_valid_o, done_o
    );
endinterface

// File: rtl/column_sum_17.sv
// ---------------------------------------------------------------------------
// column_sum_17
//   Vertical 17-tap column summer sitting directly behind the 16-row line
//   buffer. Each valid beat carries the 17 vertically aligned pixels of one
//   column; their sum leaves a 3-stage adder pipeline exactly 3 cycles later.
//   A column/row position tracker suppresses sums until 16 rows have been
//   buffered, so only columns with a complete 17-row window are emitted.
//
// Parameters
//   WIDTH  pixels per image row (must equal the line buffer depth)
//   CW     column counter width, 2**CW >= WIDTH
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    column_sum_17_if.slave: taps/valid/done in, sum/col/valid/done out
//
// Pipeline
//   S1  six 10-bit partial sums over taps {0-2},{3-5},{6-8},{9-11},{12-14},
//       {15-16}; column index captured alongside
//   S2  two 12-bit sums {p0,p1,p2} and {p3,p4,p5}
//   S3  13-bit final sum (max 17*255 = 4335, never overflows)
//   Registers advance every cycle; there is no stall.
// ---------------------------------------------------------------------------
module column_sum_17 #(
    parameter int WIDTH = 17,
    parameter int CW    = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    column_sum_17_if.slave  bus
);

    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
    localparam logic [4:0]    ROWS_BUF = 5'd16;

    // -----------------------------------------------------------------------
    // Tap gathering
    // -----------------------------------------------------------------------
    logic [7:0] tap [17];

    assign tap[0]  = bus.data0_i;
    assign tap[1]  = bus.data1_i;
    assign tap[2]  = bus.data2_i;
    assign tap[3]  = bus.data3_i;
    assign tap[4]  = bus.data4_i;
    assign tap[5]  = bus.data5_i;
    assign tap[6]  = bus.data6_i;
    assign tap[7]  = bus.data7_i;
    assign tap[8]  = bus.data8_i;
    assign tap[9]  = bus.data9_i;
    assign tap[10] = bus.data10_i;
    assign tap[11] = bus.data11_i;
    assign tap[12] = bus.data12_i;
    assign tap[13] = bus.data13_i;
    assign tap[14] = bus.data14_i;
    assign tap[15] = bus.data15_i;
    assign tap[16] = bus.data16_i;

    // -----------------------------------------------------------------------
    // Position tracking
    //   row_cnt counts completed rows and saturates at 16; row_full is taken
    //   from the registered count, i.e. before this cycle's update, so the
    //   first beat of the 17th row is already accepted.
    // -----------------------------------------------------------------------
    logic [CW-1:0] col_cnt;
    logic [4:0]    row_cnt;
    logic          row_full;
    logic          accept;

    assign row_full = (row_cnt == ROWS_BUF);
    assign accept   = bus.valid_i & row_full;

    // NOTE: state registers use non-blocking assignments so every always_ff
    // sees the pre-edge values of the others, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (bus.done_i) begin
            // End of frame wins over a coincident beat: that beat is still
            // sampled (accept uses the old counters) but the frame restarts.
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (bus.valid_i) begin
            if (col_cnt == LAST_COL) begin
                col_cnt <= '0;
                if (!row_full) begin
                    row_cnt <= row_cnt + 5'd1;
                end
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // S1: partial sums of three taps (last group has two)
    // -----------------------------------------------------------------------
    logic [9:0]    p [6];
    logic [CW-1:0] col_s1;
    logic          vld_s1;
    logic          done_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                p[i] <= '0;
            end
            col_s1  <= '0;
            vld_s1  <= 1'b0;
            done_s1 <= 1'b0;
        end else begin
            vld_s1  <= accept;
            done_s1 <= bus.done_i;
            // Data registers only load on accepted columns; bubbles carry
            // just the cleared qualifier.
            if (accept) begin
                p[0]   <= 10'(tap[0])  + 10'(tap[1])  + 10'(tap[2]);
                p[1]   <= 10'(tap[3])  + 10'(tap[4])  + 10'(tap[5]);
                p[2]   <= 10'(tap[6])  + 10'(tap[7])  + 10'(tap[8]);
                p[3]   <= 10'(tap[9])  + 10'(tap[10]) + 10'(tap[11]);
                p[4]   <= 10'(tap[12]) + 10'(tap[13]) + 10'(tap[14]);
                p[5]   <= 10'(tap[15]) + 10'(tap[16]);
                col_s1 <= col_cnt;
            end
        end
    end

    // -----------------------------------------------------------------------
    // S2: two 12-bit group sums
    // -----------------------------------------------------------------------
    logic [11:0]   s0;
    logic [11:0]   s1;
    logic [CW-1:0] col_s2;
    logic          vld_s2;
    logic          done_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0      <= '0;
            s1      <= '0;
            col_s2  <= '0;
            vld_s2  <= 1'b0;
            done_s2 <= 1'b0;
        end else begin
            vld_s2  <= vld_s1;
            done_s2 <= done_s1;
            if (vld_s1) begin
                s0     <= 12'(p[0]) + 12'(p[1]) + 12'(p[2]);
                s1     <= 12'(p[3]) + 12'(p[4]) + 12'(p[5]);
                col_s2 <= col_s1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // S3: final sum and output registers
    //   sum_o/col_o hold their last value while no valid sum is presented.
    // -----------------------------------------------------------------------
    logic [12:0]   sum_q;
    logic [CW-1:0] col_q;
    logic          sum_valid_q;
    logic          done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            col_q       <= '0;
            sum_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sum_valid_q <= vld_s2;
            done_q      <= done_s2;
            if (vld_s2) begin
                sum_q <= 13'(s0) + 13'(s1);
                col_q <= col_s2;
            end
        end
    end

    assign bus.sum_o       = sum_q;
    assign bus.col_o       = col_q;
    assign bus.sum_valid_o = sum_valid_q;
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_column_sum_17.sv
// ---------------------------------------------------------------------------
// tb_column_sum_17
//   Directed bench for column_sum_17. The driver issues beats and, for each
//   beat that must produce an output event (sum and/or done), pushes the
//   hand-computed expectation together with the cycle it must appear in.
//   An independent monitor pops one entry per observed output event on the
//   falling edge and compares value, column, qualifiers and timing.
// ---------------------------------------------------------------------------
module tb_column_sum_17;

    localparam int WIDTH = 17;
    localparam int CW    = 10;

    typedef logic [7:0] taps_t [17];

    typedef struct {
        logic sv;
        int   sum;
        int   col;
        logic done;
        int   cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;
    exp_t q [$];

    column_sum_17_if #(.CW(CW)) bus ();

    column_sum_17 #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic taps_t fill(input logic [7:0] v);
        taps_t t;
        for (int k = 0; k < 17; k++) t[k] = v;
        return t;
    endfunction

    task automatic set_taps(input taps_t t);
        bus.data0_i  = t[0];
        bus.data1_i  = t[1];
        bus.data2_i  = t[2];
        bus.data3_i  = t[3];
        bus.data4_i  = t[4];
        bus.data5_i  = t[5];
        bus.data6_i  = t[6];
        bus.data7_i  = t[7];
        bus.data8_i  = t[8];
        bus.data9_i  = t[9];
        bus.data10_i = t[10];
        bus.data11_i = t[11];
        bus.data12_i = t[12];
        bus.data13_i = t[13];
        bus.data14_i = t[14];
        bus.data15_i = t[15];
        bus.data16_i = t[16];
    endtask

    // One input cycle. es/d say whether an output event is expected 3 cycles on.
    task automatic beat(input logic v, input taps_t t, input logic d,
                        input logic es, input int esum, input int ecol);
        exp_t e;
        bus.valid_i = v;
        bus.done_i  = d;
        set_taps(t);
        if (es || d) begin
            e.sv   = es;
            e.sum  = esum;
            e.col  = ecol;
            e.done = d;
            e.cyc  = cyc + 3;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        bus.done_i  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_rows(input int beats);
        for (int i = 0; i < beats; i++) begin
            beat(1'b1, fill(8'(i * 7 + 3)), 1'b0, 1'b0, 0, 0);
        end
    endtask

    // Monitor: every output event must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && (bus.sum_valid_o || bus.done_o)) begin
            if (q.size() == 0) begin
                check("unexpected_output", int'({bus.sum_valid_o, bus.done_o}), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("sum_valid_o", int'(bus.sum_valid_o), int'(e.sv));
                check("done_o", int'(bus.done_o), int'(e.done));
                if (e.sv) begin
                    check("sum_o", int'(bus.sum_o), e.sum);
                    check("col_o", int'(bus.col_o), e.col);
                end
            end
        end
    end

    initial begin
        taps_t ramp;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.valid_i = 1'b0;
        bus.done_i  = 1'b0;
        set_taps(fill(8'd0));

        // 1. Reset while inputs toggle; outputs must stay cleared.
        for (int i = 0; i < 4; i++) begin
            bus.valid_i = 1'b1;
            bus.done_i  = 1'(i % 2);
            set_taps(fill(8'(i * 37 + 5)));
            @(negedge clk);
            check("rst_sum_o", int'(bus.sum_o), 0);
            check("rst_col_o", int'(bus.col_o), 0);
            check("rst_sum_valid_o", int'(bus.sum_valid_o), 0);
            check("rst_done_o", int'(bus.done_o), 0);
        end
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.done_i  = 1'b0;
        rst_n = 1'b1;
        idle(4);
        @(negedge clk);
        check("post_rst_sum_o", int'(bus.sum_o), 0);
        check("post_rst_col_o", int'(bus.col_o), 0);
        check("post_rst_sum_valid_o", int'(bus.sum_valid_o), 0);
        check("post_rst_done_o", int'(bus.done_o), 0);
        @(posedge clk);
        #1;

        // 2. 16 rows produce nothing; row 17 of all 255 gives 4335 per column.
        fill_rows(16 * WIDTH);
        for (int c = 0; c < WIDTH; c++) begin
            beat(1'b1, fill(8'd255), 1'b0, 1'b1, 4335, c);
        end
        idle(4);

        // 3. Ramp taps 1..17 -> 153 at column 0; value holds afterwards.
        for (int k = 0; k < 17; k++) ramp[k] = 8'(k + 1);
        beat(1'b1, ramp, 1'b0, 1'b1, 153, 0);
        idle(5);
        @(negedge clk);
        check("hold_sum_o", int'(bus.sum_o), 153);
        check("hold_col_o", int'(bus.col_o), 0);
        check("hold_sum_valid_o", int'(bus.sum_valid_o), 0);
        @(posedge clk);
        #1;

        // 4. Gapped valid: bubbles carry garbage taps and must not count.
        beat(1'b1, fill(8'd10), 1'b0, 1'b1, 170, 1);
        beat(1'b0, fill(8'd99), 1'b0, 1'b0, 0, 0);
        beat(1'b1, fill(8'd20), 1'b0, 1'b1, 340, 2);
        beat(1'b0, fill(8'd99), 1'b0, 1'b0, 0, 0);
        beat(1'b1, fill(8'd30), 1'b0, 1'b1, 510, 3);
        beat(1'b0, fill(8'd99), 1'b0, 1'b0, 0, 0);
        idle(4);

        // 5. done_i with the last column: final sum and done_o coincide.
        for (int c = 4; c < WIDTH - 1; c++) begin
            beat(1'b1, fill(8'd1), 1'b0, 1'b1, 17, c);
        end
        beat(1'b1, fill(8'd2), 1'b1, 1'b1, 34, 16);
        beat(1'b1, fill(8'd255), 1'b0, 1'b0, 0, 0);   // new frame: no sum
        idle(5);

        // Partial frame: done_i alone still produces a done_o pulse.
        beat(1'b0, fill(8'd0), 1'b1, 1'b0, 0, 0);
        idle(5);

        // 6. Reset with two sums in flight discards them and the row count.
        fill_rows(16 * WIDTH);
        beat(1'b1, fill(8'd50), 1'b0, 1'b0, 0, 0);
        beat(1'b1, fill(8'd50), 1'b0, 1'b0, 0, 0);
        bus.valid_i = 1'b0;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(6);
        @(negedge clk);
        check("flush_sum_o", int'(bus.sum_o), 0);
        check("flush_col_o", int'(bus.col_o), 0);
        @(posedge clk);
        #1;
        fill_rows(16 * WIDTH);
        beat(1'b1, fill(8'd3), 1'b0, 1'b1, 51, 0);
        idle(6);

        // Bounded drain of anything still outstanding.
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
